// File: rtl/dsp48_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : dsp48_mac_seq
// Brief    : Initiator-side sequencer that drives a DSP48A1 slice through an
//            N-beat multiply-accumulate and returns the final P value.
// Revision : 1.0 - initial release
// ============================================================================
module dsp48_mac_seq #(
    parameter int WIDTH     = 18,
    parameter int ACC_WIDTH = 48,
    parameter int LEN_WIDTH = 8,
    parameter int PIPE_LAT  = 3,
    parameter int OPM_DLY   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_a,
    input  logic [WIDTH-1:0]     s_b,
    output logic [WIDTH-1:0]     dsp_a,
    output logic [WIDTH-1:0]     dsp_b,
    output logic [7:0]           dsp_opmode,
    output logic                 dsp_ce,
    output logic                 dsp_rstp,
    input  logic [ACC_WIDTH-1:0] dsp_p,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 done,
    output logic                 err
);

    // Cycles spent waiting for the last beat to reach the slice P register
    localparam int DRAIN_CYC = PIPE_LAT + OPM_DLY;
    localparam int DCW       = $clog2(DRAIN_CYC + 1);

    // Slice OPMODE encodings used by the sequencer
    localparam logic [7:0] OPM_LOAD = 8'h01;   // P = M
    localparam logic [7:0] OPM_ACC  = 8'h09;   // P = P + M
    localparam logic [7:0] OPM_HOLD = 8'h08;   // P = P

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                       state;
    logic [LEN_WIDTH-1:0]         beat_cnt;
    logic [DCW-1:0]               drain_cnt;
    logic                         first_beat;
    // Stage 0 is aligned with dsp_a/dsp_b; stages 1..OPM_DLY add the lag
    logic [OPM_DLY:0][7:0]        opm_sr;
    logic                         beat_acc;
    logic [7:0]                   load_tag;

    // s_ready is a register, so the handshake has no s_valid->s_ready path
    assign beat_acc   = s_valid & s_ready;
    assign dsp_opmode = opm_sr[OPM_DLY];

    // Tag for the slot issued this LOAD cycle: load, accumulate or bubble hold
    always_comb begin
        load_tag = OPM_HOLD;
        if (beat_acc) begin
            load_tag = first_beat ? OPM_LOAD : OPM_ACC;
        end
    end

    // Control FSM with registered status/handshake/slice-control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            beat_cnt   <= '0;
            drain_cnt  <= '0;
            first_beat <= 1'b0;
            busy       <= 1'b0;
            s_ready    <= 1'b0;
            dsp_ce     <= 1'b0;
            dsp_rstp   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            result     <= '0;
        end else begin
            dsp_rstp <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            err <= 1'b1;
                        end else begin
                            state      <= S_LOAD;
                            beat_cnt   <= len;
                            first_beat <= 1'b1;
                            dsp_rstp   <= 1'b1;
                            busy       <= 1'b1;
                            s_ready    <= 1'b1;
                            dsp_ce     <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (beat_acc) begin
                        first_beat <= 1'b0;
                        beat_cnt   <= beat_cnt - LEN_WIDTH'(1);
                        if (beat_cnt == LEN_WIDTH'(1)) begin
                            state     <= S_DRAIN;
                            s_ready   <= 1'b0;
                            drain_cnt <= DCW'(DRAIN_CYC - 1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= S_DONE;
                        dsp_ce <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - DCW'(1);
                    end
                end
                S_DONE: begin
                    // Slice is frozen (ce=0) so dsp_p is stable final P here
                    result <= dsp_p;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand registers and OPMODE delay line feeding the slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_a  <= '0;
            dsp_b  <= '0;
            opm_sr <= '0;
        end else begin
            dsp_a <= '0;
            dsp_b <= '0;
            if (state == S_LOAD) begin
                if (beat_acc) begin
                    dsp_a <= s_a;
                    dsp_b <= s_b;
                end
                opm_sr <= {opm_sr[OPM_DLY-1:0], load_tag};
            end else if (state == S_DRAIN) begin
                opm_sr <= {opm_sr[OPM_DLY-1:0], OPM_HOLD};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsp48_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp48_mac_seq
// Brief    : Self-checking bench for dsp48_mac_seq with a behavioural DSP48A1
//            slice model and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp48_mac_seq;

    localparam int WIDTH     = 18;
    localparam int ACC_WIDTH = 48;
    localparam int LEN_WIDTH = 8;
    localparam int PIPE_LAT  = 3;
    localparam int OPM_DLY   = 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [LEN_WIDTH-1:0] len = '0;
    logic                 busy;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [WIDTH-1:0]     s_a = '0;
    logic [WIDTH-1:0]     s_b = '0;
    logic [WIDTH-1:0]     dsp_a;
    logic [WIDTH-1:0]     dsp_b;
    logic [7:0]           dsp_opmode;
    logic                 dsp_ce;
    logic                 dsp_rstp;
    logic [ACC_WIDTH-1:0] dsp_p;
    logic [ACC_WIDTH-1:0] result;
    logic                 done;
    logic                 err;

    dsp48_mac_seq #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .LEN_WIDTH (LEN_WIDTH),
        .PIPE_LAT  (PIPE_LAT),
        .OPM_DLY   (OPM_DLY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_a        (s_a),
        .s_b        (s_b),
        .dsp_a      (dsp_a),
        .dsp_b      (dsp_b),
        .dsp_opmode (dsp_opmode),
        .dsp_ce     (dsp_ce),
        .dsp_rstp   (dsp_rstp),
        .dsp_p      (dsp_p),
        .result     (result),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural DSP48A1 slice: B reg, M reg, extra stage, OPMODE regs, P
    // ------------------------------------------------------------------
    logic signed [47:0] ext_a, ext_b, prod;
    logic signed [47:0] m_p1, m_p2, m_p3, slice_p;
    logic [7:0]         m_o1, m_o2;

    assign ext_a = {{(48-WIDTH){dsp_a[WIDTH-1]}}, dsp_a};
    assign ext_b = {{(48-WIDTH){dsp_b[WIDTH-1]}}, dsp_b};
    assign prod  = ext_a * ext_b;
    assign dsp_p = slice_p;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p1 <= '0; m_p2 <= '0; m_p3 <= '0; slice_p <= '0;
            m_o1 <= '0; m_o2 <= '0;
        end else begin
            if (dsp_ce) begin
                m_p1 <= prod; m_p2 <= m_p1; m_p3 <= m_p2;
                m_o1 <= dsp_opmode; m_o2 <= m_o1;
                if (!dsp_rstp) begin
                    case (m_o2)
                        8'h01:   slice_p <= m_p3;
                        8'h09:   slice_p <= slice_p + m_p3;
                        8'h08:   slice_p <= slice_p;
                        default: slice_p <= '0;
                    endcase
                end
            end
            if (dsp_rstp) slice_p <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter and passive event monitor
    // ------------------------------------------------------------------
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, rstp_cnt = 0, ce_cnt = 0, busy_cnt = 0;
    int rstp_cyc = 1 << 30;
    logic [7:0] opm_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (busy) busy_cnt++;
        if (dsp_rstp) begin
            rstp_cnt++;
            rstp_cyc = cyc;
        end
        if (dsp_ce) begin
            ce_cnt++;
            if (cyc >= rstp_cyc + 1 + OPM_DLY) opm_log.push_back(dsp_opmode);
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and counters
    // ------------------------------------------------------------------
    longint exp_q[$];
    int     tests = 0;
    int     fails = 0;
    logic signed [WIDTH-1:0] qa[$];
    logic signed [WIDTH-1:0] qb[$];
    int     last_acc_cyc = 0;
    int     done_cyc = 0;
    int     poke_at = -1;

    task automatic send_beat(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
        bit acc = 1'b0;
        s_valid = 1'b1; s_a = a; s_b = b;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            if (s_ready) begin
                acc = 1'b1;
                last_acc_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        if (!acc) begin
            tests++; fails++;
            $display("FAIL beat_accept: s_ready never seen, got 0 required 1");
        end
    endtask

    task automatic idle_cycles(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                done_cyc = cyc;
            end
        end
    endtask

    // Launch a job from qa/qb, optional bubble after beat bubble_at, and
    // compare the returned result against the scoreboard head.
    task automatic run_job(input int n, input int bubble_at, input int bubble_len, input longint expv);
        bit ok;
        longint e;
        exp_q.push_back(expv);
        opm_log.delete();
        start = 1'b1; len = LEN_WIDTH'(n);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == poke_at) begin
                start = 1'b1; len = 8'd3;
            end
            send_beat(qa[i], qb[i]);
            start = 1'b0;
            if (i == bubble_at) idle_cycles(bubble_len);
        end
        wait_done(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL done_timeout: done got 0 required 1");
            void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: got done with no expected entry");
        end else begin
            e = exp_q.pop_front();
            if (result !== e[ACC_WIDTH-1:0]) begin
                fails++;
                $display("FAIL result: got %h required %h", result, e[ACC_WIDTH-1:0]);
            end
        end
    endtask

    task automatic check_opm(input string name, input logic [7:0] exp_seq[$]);
        tests++;
        if (opm_log.size() != exp_seq.size()) begin
            fails++;
            $display("FAIL %s_opm_len: got %0d required %0d", name, opm_log.size(), exp_seq.size());
        end else begin
            for (int i = 0; i < exp_seq.size(); i++) begin
                if (opm_log[i] !== exp_seq[i]) begin
                    fails++;
                    $display("FAIL %s_opm[%0d]: got %h required %h", name, i, opm_log[i], exp_seq[i]);
                    break;
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, s_ready, dsp_ce, dsp_rstp, done, err, dsp_opmode, dsp_a, dsp_b, result} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got nonzero busy=%b ready=%b ce=%b rstp=%b opm=%h result=%h required 0",
                     busy, s_ready, dsp_ce, dsp_rstp, dsp_opmode, result);
        end
        rst_n = 1'b1;
        idle_cycles(2);
        tests++;
        if ({busy, s_ready, dsp_ce, done, err} !== 5'b0) begin
            fails++;
            $display("FAIL idle_after_reset: got %b required 00000", {busy, s_ready, dsp_ce, done, err});
        end
    endtask

    task automatic test_basic();
        int d0 = done_cnt, r0 = rstp_cnt, c0 = ce_cnt;
        logic [7:0] seq[$] = '{8'h01, 8'h09, 8'h09, 8'h09, 8'h08, 8'h08};
        qa = '{1, 2, 3, 4}; qb = '{2, 2, 2, 2};
        run_job(4, -1, 0, 64'd20);
        check_opm("basic", seq);
        idle_cycles(3);
        tests++;
        if (rstp_cnt - r0 != 1) begin
            fails++; $display("FAIL basic_rstp: got %0d pulses required 1", rstp_cnt - r0);
        end
        tests++;
        if (done_cnt - d0 != 1) begin
            fails++; $display("FAIL basic_done: got %0d pulses required 1", done_cnt - d0);
        end
        tests++;
        if (ce_cnt - c0 != 4 + PIPE_LAT + OPM_DLY) begin
            fails++; $display("FAIL basic_ce: got %0d cycles required %0d", ce_cnt - c0, 4 + PIPE_LAT + OPM_DLY);
        end
    endtask

    task automatic test_bubble();
        logic [7:0] seq[$] = '{8'h01, 8'h08, 8'h08, 8'h09, 8'h09, 8'h08, 8'h08};
        qa = '{3, -4, 5}; qb = '{7, 7, 7};
        run_job(3, 0, 2, 64'd28);
        check_opm("bubble", seq);
    endtask

    task automatic test_single();
        qa = '{-3}; qb = '{5};
        run_job(1, -1, 0, -64'sd15);
        tests++;
        if (done_cyc - last_acc_cyc != 2 + PIPE_LAT + OPM_DLY) begin
            fails++;
            $display("FAIL single_latency: got %0d cycles required %0d", done_cyc - last_acc_cyc, 2 + PIPE_LAT + OPM_DLY);
        end
    endtask

    task automatic test_len_zero();
        int e0 = err_cnt, b0 = busy_cnt, c0 = ce_cnt, r0 = rstp_cnt;
        start = 1'b1; len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        idle_cycles(5);
        tests++;
        if (err_cnt - e0 != 1) begin
            fails++; $display("FAIL len0_err: got %0d cycles required 1", err_cnt - e0);
        end
        tests++;
        if ((busy_cnt - b0) + (ce_cnt - c0) + (rstp_cnt - r0) != 0) begin
            fails++;
            $display("FAIL len0_activity: got busy=%0d ce=%0d rstp=%0d required 0",
                     busy_cnt - b0, ce_cnt - c0, rstp_cnt - r0);
        end
    endtask

    task automatic test_start_ignored();
        int d0 = done_cnt, r0 = rstp_cnt;
        qa = '{1, 2, 3, 4, 5}; qb = '{3, 3, 3, 3, 3};
        poke_at = 2;
        run_job(5, -1, 0, 64'd45);
        poke_at = -1;
        idle_cycles(12);
        tests++;
        if (done_cnt - d0 != 1 || rstp_cnt - r0 != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL start_ignored: got done=%0d rstp=%0d busy=%b required 1 1 0",
                     done_cnt - d0, rstp_cnt - r0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        qa = '{1, 1}; qb = '{1, 1};
        start = 1'b1; len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        send_beat(6, 6);
        send_beat(7, 7);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, s_ready, dsp_ce, dsp_rstp, done, err, dsp_opmode, dsp_a, dsp_b, result} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got busy=%b ready=%b ce=%b opm=%h a=%h result=%h required 0",
                     busy, s_ready, dsp_ce, dsp_opmode, dsp_a, result);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(2);
        tests++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_mid_done: got done=%0d busy=%b required 0 0", done_cnt - d0, busy);
        end
        run_job(2, -1, 0, 64'd2);
    endtask

    task automatic test_back_to_back();
        qa.delete(); qb.delete();
        for (int i = 0; i < 255; i++) begin
            qa.push_back(1); qb.push_back(1);
        end
        run_job(255, -1, 0, 64'd255);
        qa = '{2, 3}; qb = '{4, 4};
        run_job(2, -1, 0, 64'd20);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubble();
        test_single();
        test_len_zero();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        idle_cycles(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
